// File: rtl/led_output_ctrl.sv
// LED output controller: four write/readable registers that drive each LED channel
// as static, blinking, PWM-dimmed or blinking-PWM.
module led_output_ctrl #(
   parameter int unsigned N_LED      = 4,
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned BLINK_BITS = 16
) (
   input  logic             CLK_mips,
   input  logic             RST,
   input  logic             WE,
   input  logic [1:0]       addr,
   input  logic [31:0]      write_data,
   output logic [31:0]      read_data,
   output logic [N_LED-1:0] LED
);

   localparam logic [1:0] AddrData  = 2'd0;
   localparam logic [1:0] AddrMode  = 2'd1;
   localparam logic [1:0] AddrDuty  = 2'd2;
   localparam logic [1:0] AddrBlink = 2'd3;

   logic [N_LED-1:0]      data_q, data_d;
   logic [2*N_LED-1:0]    mode_q, mode_d;
   logic [PWM_BITS-1:0]   duty_q, duty_d;
   logic [BLINK_BITS-1:0] blink_q, blink_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [N_LED-1:0]      led_q, led_d;
   logic                  pwm_on;
   logic                  unused_wdata;

   assign unused_wdata = ^write_data;
   assign pwm_on       = (pwm_cnt_q < duty_q);

   always_comb begin
      data_d  = data_q;
      mode_d  = mode_q;
      duty_d  = duty_q;
      blink_d = blink_q;
      if (WE) begin
         unique case (addr)
            AddrData:  data_d  = write_data[N_LED-1:0];
            AddrMode:  mode_d  = write_data[2*N_LED-1:0];
            AddrDuty:  duty_d  = write_data[PWM_BITS-1:0];
            AddrBlink: blink_d = write_data[BLINK_BITS-1:0];
            default:   ;
         endcase
      end
   end

   always_comb begin
      pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
      blink_cnt_d   = blink_cnt_q - BLINK_BITS'(1);
      blink_phase_d = blink_phase_q;
      // A BLINK write restarts the countdown without disturbing the phase.
      if (WE && (addr == AddrBlink)) begin
         blink_cnt_d = write_data[BLINK_BITS-1:0];
      end else if (blink_cnt_q == '0) begin
         blink_cnt_d   = blink_q;
         blink_phase_d = ~blink_phase_q;
      end
   end

   always_comb begin
      led_d = '0;
      for (int i = 0; i < N_LED; i++) begin
         unique case (mode_q[2*i +: 2])
            2'b00:   led_d[i] = data_q[i];
            2'b01:   led_d[i] = data_q[i] & blink_phase_q;
            2'b10:   led_d[i] = data_q[i] & pwm_on;
            default: led_d[i] = data_q[i] & blink_phase_q & pwm_on;
         endcase
      end
   end

   always_comb begin
      read_data = '0;
      unique case (addr)
         AddrData:  read_data = 32'(data_q);
         AddrMode:  read_data = 32'(mode_q);
         AddrDuty:  read_data = 32'(duty_q);
         AddrBlink: read_data = 32'(blink_q);
         default:   read_data = '0;
      endcase
   end

   always_ff @(posedge CLK_mips or posedge RST) begin
      if (RST) begin
         data_q        <= '0;
         mode_q        <= '0;
         duty_q        <= '0;
         blink_q       <= '0;
         pwm_cnt_q     <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         led_q         <= '0;
      end else begin
         data_q        <= data_d;
         mode_q        <= mode_d;
         duty_q        <= duty_d;
         blink_q       <= blink_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         led_q         <= led_d;
      end
   end

   assign LED = led_q;

endmodule

// File: doc/led_output_ctrl.md
LED_OUTPUT_CTRL -- requirements
Module: led_output_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 4: number of LED channels, legal range 1..8.
REQ-002 SHALL have parameter PWM_BITS, default 8: PWM counter and duty width, legal range 2..16.
REQ-003 SHALL have parameter BLINK_BITS, default 16: blink divider width, legal range 1..24.
REQ-004 SHALL have port CLK_mips  input  1: system clock; all state updates on the rising edge.
REQ-005 SHALL have port RST  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port WE  input  1: write enable, sampled on the rising edge of CLK_mips.
REQ-007 SHALL have port addr  input  2: register select (0 DATA, 1 MODE, 2 DUTY, 3 BLINK).
REQ-008 SHALL have port write_data  input  32: write bus; only the register's defined low bits are used.
REQ-009 SHALL have port read_data  output  32: contents of the selected register, zero-extended.
REQ-010 SHALL have port LED  output  N_LED: registered LED pin drive.

Function
REQ-011 SHALL hold register DATA[N_LED-1:0], loaded from write_data[N_LED-1:0] when WE is high and addr is 0.
REQ-012 SHALL hold register MODE[2*N_LED-1:0], 2 bits per channel i at [2i+1:2i], loaded from write_data when WE is high and addr is 1.
REQ-013 SHALL hold register DUTY[PWM_BITS-1:0], loaded when WE is high and addr is 2.
REQ-014 SHALL hold register BLINK[BLINK_BITS-1:0], loaded when WE is high and addr is 3.
REQ-015 SHALL write exactly one register per cycle and leave all other registers unchanged.
REQ-016 SHALL drive read_data combinationally from addr, zero-extended to 32 bits; reads SHALL have no side effects.
REQ-017 SHALL run pwm_cnt[PWM_BITS-1:0] free, incrementing every cycle and wrapping from 2^PWM_BITS-1 to 0.
REQ-018 SHALL define pwm_on = (pwm_cnt < DUTY), unsigned: DUTY=0 is never on; DUTY=2^PWM_BITS-1 is on for all counts except the maximum.
REQ-019 SHALL count blink_cnt down by 1 each cycle; at blink_cnt==0 it SHALL reload with BLINK and toggle blink_phase; phase period = 2*(BLINK+1) cycles.
REQ-020 SHALL, with BLINK=0, toggle blink_phase every cycle.
REQ-021 SHALL, on a BLINK write, load blink_cnt with the new value at the same edge, overriding decrement and reload; blink_phase SHALL be unchanged.
REQ-022 SHALL compute the next LED[i] value from MODE bits for channel i:
- 00 static: DATA[i]
- 01 blink: DATA[i] & blink_phase
- 10 PWM: DATA[i] & pwm_on
- 11 blink-PWM: DATA[i] & blink_phase & pwm_on
REQ-023 SHALL register LED from the values of REQ-022 computed from current-cycle register and counter state; a DATA/MODE/DUTY write at edge k SHALL appear on LED at edge k+1.
REQ-024 SHALL ignore write_data bits above each register's width.
REQ-025 SHALL not reset or phase-shift pwm_cnt on a DUTY write; the new duty SHALL take effect on the next compare.

Reset
REQ-026 SHALL, while RST is high, asynchronously clear DATA, MODE, DUTY, BLINK, pwm_cnt, blink_cnt, blink_phase and LED to 0.
REQ-027 SHALL, on RST asserted mid-operation, abort blink/PWM sequences immediately; after release, counting SHALL restart from 0 on the first rising edge.
REQ-028 SHALL ignore WE while RST is high.

Verification
REQ-029 SHALL cover: N_LED=4; write DATA=0xA (MODE=0) at edge k -> LED=4'b1010 from edge k+1; read addr 0 -> 0x0000000A.
REQ-030 SHALL cover: MODE=0x0001, DATA=0x1, BLINK=3 -> LED[0] toggles every 4 cycles (period 8); LED[3:1]=0.
REQ-031 SHALL cover: PWM_BITS=8, MODE=0x0002, DATA=0x1, DUTY=64 -> LED[0] high 64 of every 256 cycles; DUTY=0 -> always 0; DUTY=255 -> 255/256.
REQ-032 SHALL cover: write_data=0xFFFFFFFF to each addr -> reads return 0xF, 0xFF, 0xFF, 0xFFFF (defaults); addr 3 write reloads blink_cnt at the same edge.
REQ-033 SHALL cover: RST pulse between clock edges during blink-PWM -> LED and all registers 0 with no clock edge; WE held high during RST has no effect.
REQ-034 SHALL cover: BLINK=0 in blink mode with DATA[0]=1 -> LED[0] alternates 1/0 every cycle.
